// File: rtl/otter_intr_controller_if.sv
// IOBUS register port of the OTTER interrupt controller.
// The processor side drives address/data/strobe; the controller returns read data and hit.
interface otter_intr_controller_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;
  logic        RD_HIT;

  modport master (
    output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
    input  RD_DATA, RD_HIT
  );

  modport slave (
    input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
    output RD_DATA, RD_HIT
  );
endinterface

// File: rtl/otter_intr_controller.sv
// Edge-triggered interrupt collector with fixed priority for the OTTER INTR input.
// Firmware masks, inspects, completes and clears sources through a 4-word IOBUS window.
module otter_intr_controller #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
  parameter int          MIN_GAP   = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] IRQ_SRC,
  otter_intr_controller_if.slave bus,
  output logic               INTR
);

  localparam int CW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef enum logic [1:0] {IDLE, ASSERT, GAP} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, dly_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [4:0]         act_q, act_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               intr_q, intr_d;

  logic               hit;
  logic [1:0]         off;
  logic               wr_pend, wr_en, wr_cmp;
  logic [NUM_SRC-1:0] rise, w1c, cmp, act_sel, req;
  logic [4:0]         prio;
  logic               arb;
  logic               unused_wdata;

  assign unused_wdata = ^bus.IOBUS_OUT;

  assign hit = (bus.IOBUS_ADDR[31:4] == BASE_ADDR[31:4])
             && (bus.IOBUS_ADDR[1:0] == 2'b00);
  assign off = bus.IOBUS_ADDR[3:2];

  assign wr_pend = bus.IOBUS_WR && hit && (off == 2'd0);
  assign wr_en   = bus.IOBUS_WR && hit && (off == 2'd1);
  assign wr_cmp  = bus.IOBUS_WR && hit && (off == 2'd3);

  always_comb begin
    bus.RD_DATA = '0;
    if (hit) begin
      unique case (off)
        2'd0:    bus.RD_DATA = 32'(pend_q);
        2'd1:    bus.RD_DATA = 32'(en_q);
        2'd2:    bus.RD_DATA = {27'd0, act_q};
        default: bus.RD_DATA = '0;
      endcase
    end
  end

  assign bus.RD_HIT = hit;
  assign INTR       = intr_q;

  // Edge detect on the synchronized level; a held level yields one edge.
  assign rise    = sync2_q & ~dly_q;
  assign act_sel = NUM_SRC'(1) << act_q;
  assign w1c     = wr_pend ? bus.IOBUS_OUT[NUM_SRC-1:0] : '0;
  assign cmp     = (state_q == ASSERT && wr_cmp) ? act_sel : '0;
  assign pend_d  = (pend_q & ~w1c & ~cmp) | rise;
  assign en_d    = wr_en ? bus.IOBUS_OUT[NUM_SRC-1:0] : en_q;
  assign req     = pend_q & en_q;

  always_comb begin
    prio = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) prio = 5'(i);
    end
  end

  // The last gap cycle re-arbitrates directly so INTR stays low MIN_GAP cycles.
  assign arb = (state_q == IDLE)
            || (state_q == GAP && cnt_q == '0);

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    intr_d  = 1'b0;
    unique case (state_q)
      ASSERT: begin
        intr_d = 1'b1;
        if (wr_cmp || !(|(pend_d & act_sel))) begin
          state_d = GAP;
          cnt_d   = CW'(MIN_GAP - 1);
          intr_d  = 1'b0;
        end
      end
      GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase
    if (arb) begin
      state_d = IDLE;
      if (|req) begin
        state_d = ASSERT;
        act_d   = prio;
        intr_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dly_q   <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      act_q   <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      intr_q  <= 1'b0;
    end else begin
      sync1_q <= IRQ_SRC;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      pend_q  <= pend_d;
      en_q    <= en_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      intr_q  <= intr_d;
    end
  end

endmodule

// File: tb/tb_otter_intr_controller.sv
// Self-checking bench for otter_intr_controller.
// Register vectors go through a scoreboard queue; service sequences are hand written.
module tb_otter_intr_controller;

  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam logic [31:0] A_PEND = BASE;
  localparam logic [31:0] A_EN   = BASE + 32'h4;
  localparam logic [31:0] A_ACT  = BASE + 32'h8;
  localparam logic [31:0] A_CMP  = BASE + 32'hC;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] IRQ_SRC;
  logic       INTR;

  otter_intr_controller_if bus ();

  otter_intr_controller #(
    .NUM_SRC   (8),
    .BASE_ADDR (BASE),
    .MIN_GAP   (2)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .IRQ_SRC (IRQ_SRC),
    .bus     (bus),
    .INTR    (INTR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       nm;
    logic        hit;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    string       nm;
    logic        do_wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic        hit;
    logic [31:0] data;
  } vec_t;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic nedge(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = d;
    bus.IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    bus.IOBUS_WR   = 1'b0;
    @(negedge CLK);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_WR   = 1'b0;
    #1;
    d = bus.RD_DATA;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(nm, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vt[$];
    exp_t        e;
    logic [31:0] d;
    int          svc;

    RST_N          = 1'b0;
    IRQ_SRC        = '0;
    bus.IOBUS_ADDR = '0;
    bus.IOBUS_OUT  = '0;
    bus.IOBUS_WR   = 1'b0;
    #1;
    chk("reset_intr", 32'(INTR), 32'd0);
    rd_chk("reset_pend", A_PEND, 32'h0);
    rd_chk("reset_en", A_EN, 32'h0);
    rd_chk("reset_act", A_ACT, 32'h0);
    nedge(2);
    RST_N = 1'b1;
    nedge(1);

    // T1: single source latency
    wr(A_EN, 32'h08);
    IRQ_SRC[3] = 1'b1;
    nedge(2);
    rd_chk("t1_pend_e2", A_PEND, 32'h00);
    nedge(1);
    rd_chk("t1_pend_e3", A_PEND, 32'h08);
    chk("t1_intr_e3", 32'(INTR), 32'd0);
    nedge(1);
    chk("t1_intr_e4", 32'(INTR), 32'd1);
    rd_chk("t1_act", A_ACT, 32'd3);

    // T2: no preemption, gap, then next source
    IRQ_SRC[1] = 1'b1;
    wr(A_EN, 32'h0A);
    nedge(3);
    chk("t2_intr_hold", 32'(INTR), 32'd1);
    rd_chk("t2_act_hold", A_ACT, 32'd3);
    rd_chk("t2_pend_both", A_PEND, 32'h0A);
    wr(A_CMP, 32'h0);
    chk("t2_gap1", 32'(INTR), 32'd0);
    nedge(1);
    chk("t2_gap2", 32'(INTR), 32'd0);
    nedge(1);
    chk("t2_reassert", 32'(INTR), 32'd1);
    rd_chk("t2_act_next", A_ACT, 32'd1);
    rd_chk("t2_pend_next", A_PEND, 32'h02);
    wr(A_CMP, 32'h0);
    nedge(3);
    chk("t2_idle", 32'(INTR), 32'd0);
    rd_chk("t2_pend_empty", A_PEND, 32'h00);
    IRQ_SRC = '0;

    // T3: pending while masked, then enable
    wr(A_EN, 32'h00);
    IRQ_SRC[5] = 1'b1;
    nedge(2);
    IRQ_SRC[5] = 1'b0;
    nedge(3);
    rd_chk("t3_pend", A_PEND, 32'h20);
    chk("t3_masked", 32'(INTR), 32'd0);
    wr(A_EN, 32'h20);
    chk("t3_edge1", 32'(INTR), 32'd0);
    nedge(1);
    chk("t3_edge2", 32'(INTR), 32'd1);
    rd_chk("t3_act", A_ACT, 32'd5);
    wr(A_CMP, 32'h0);
    nedge(3);

    // T4: W1C withdraws an active interrupt
    wr(A_EN, 32'h04);
    IRQ_SRC[2] = 1'b1;
    nedge(4);
    chk("t4_intr", 32'(INTR), 32'd1);
    rd_chk("t4_act", A_ACT, 32'd2);
    wr(A_PEND, 32'h04);
    chk("t4_withdraw", 32'(INTR), 32'd0);
    rd_chk("t4_pend", A_PEND, 32'h00);
    nedge(4);
    chk("t4_stay_low", 32'(INTR), 32'd0);
    IRQ_SRC[2] = 1'b0;

    // T5: set beats W1C in the same cycle; held level serviced once
    wr(A_EN, 32'h00);
    IRQ_SRC[0] = 1'b1;
    nedge(2);
    IRQ_SRC[0] = 1'b0;
    nedge(4);
    rd_chk("t5_pend_pre", A_PEND, 32'h01);
    IRQ_SRC[0] = 1'b1;
    nedge(2);
    wr(A_PEND, 32'h01);
    rd_chk("t5_set_wins", A_PEND, 32'h01);
    wr(A_EN, 32'h01);
    svc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (INTR) begin
        svc++;
        wr(A_CMP, 32'h0);
      end
    end
    chk("t5_one_service", 32'(svc), 32'd1);
    rd_chk("t5_pend_post", A_PEND, 32'h00);

    // T6: asynchronous reset mid-service
    wr(A_EN, 32'h10);
    IRQ_SRC[4] = 1'b1;
    nedge(4);
    chk("t6_intr", 32'(INTR), 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("t6_async_intr", 32'(INTR), 32'd0);
    rd_chk("t6_pend", A_PEND, 32'h00);
    rd_chk("t6_en", A_EN, 32'h00);
    IRQ_SRC = '0;
    nedge(2);
    RST_N = 1'b1;
    nedge(1);

    // Register map vectors
    vt.push_back('{"oob_read",   1'b0, 32'h0, 32'h0, BASE + 32'h10, 1'b0, 32'h0});
    vt.push_back('{"below_base", 1'b0, 32'h0, 32'h0, BASE - 32'h4,  1'b0, 32'h0});
    vt.push_back('{"misalign",   1'b0, 32'h0, 32'h0, BASE + 32'h2,  1'b0, 32'h0});
    vt.push_back('{"en_mask",    1'b1, A_EN, 32'hFFFF_FFFF, A_EN, 1'b1, 32'h0000_00FF});
    vt.push_back('{"en_mis_wr",  1'b1, A_EN + 32'h1, 32'h0, A_EN, 1'b1, 32'h0000_00FF});
    vt.push_back('{"act_ro",     1'b1, A_ACT, 32'h7, A_ACT, 1'b1, 32'h0});
    vt.push_back('{"cmp_rd0",    1'b1, A_CMP, 32'hFFFF_FFFF, A_CMP, 1'b1, 32'h0});
    vt.push_back('{"pend_idle",  1'b0, 32'h0, 32'h0, A_PEND, 1'b1, 32'h0});
    vt.push_back('{"en_write",   1'b1, A_EN, 32'h0000_0055, A_EN, 1'b1, 32'h0000_0055});
    vt.push_back('{"en_clear",   1'b1, A_EN, 32'h0, A_EN, 1'b1, 32'h0});

    foreach (vt[k]) begin
      if (vt[k].do_wr) wr(vt[k].wa, vt[k].wd);
      sbq.push_back('{vt[k].nm, vt[k].hit, vt[k].data});
      rd(vt[k].ra, d);
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sbq.pop_front();
        chk({e.nm, "_hit"}, 32'(bus.RD_HIT), 32'(e.hit));
        chk({e.nm, "_data"}, d, e.data);
      end
      nedge(1);
    end
    chk("vec_intr_idle", 32'(INTR), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
